// File: rtl/fg_profile_sequencer.sv
// Profile sequencer for the function generator: stores NUM_SLOTS config words,
// steps through them on start, dwelling a programmed number of output samples per step.
module fg_profile_sequencer #(
  parameter int unsigned CONFIG_REG_BITWIDTH = 64,
  parameter int unsigned NUM_SLOTS           = 4,
  parameter int unsigned SLOT_BITS           = 2,
  parameter int unsigned DWELL_BITWIDTH      = 16
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [SLOT_BITS-1:0]           wr_slot_i,
  input  logic [2:0]                     wr_byte_i,
  input  logic [7:0]                     wr_data_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           loop_i,
  input  logic [SLOT_BITS-1:0]           last_slot_i,
  input  logic [DWELL_BITWIDTH-1:0]      dwell_i,
  input  logic                           sample_strb_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           fg_enable_o,
  output logic [SLOT_BITS-1:0]           active_slot_o,
  output logic                           busy_o,
  output logic                           done_strb_o
);

  localparam int unsigned NUM_BYTES = CONFIG_REG_BITWIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [CONFIG_REG_BITWIDTH-1:0]   slot_q [NUM_SLOTS];
  logic [CONFIG_REG_BITWIDTH-1:0]   cr_q, cr_d;
  logic [SLOT_BITS-1:0]             act_q, act_d, slot_nxt;
  logic [DWELL_BITWIDTH-1:0]        cnt_q, cnt_d, dwell_m1;
  logic                             en_q, en_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             wr_en, byte_ok;

  assign CR_bus_o      = cr_q;
  assign fg_enable_o   = en_q;
  assign active_slot_o = act_q;
  assign busy_o        = busy_q;
  assign done_strb_o   = done_q;

  // The profile on the bus is write-protected while a sequence is using it.
  always_comb begin
    wr_ready_o = 1'b1;
    if (state_q == ST_LOAD || state_q == ST_RUN) begin
      wr_ready_o = (wr_slot_i != act_q);
    end
  end

  assign wr_en   = wr_valid_i && wr_ready_o;
  assign byte_ok = (32'(wr_byte_i) < NUM_BYTES);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (wr_en && byte_ok) begin
      slot_q[wr_slot_i][8*wr_byte_i +: 8] <= wr_data_i;
    end
  end

  // Dwell of zero behaves as one sample per step.
  assign dwell_m1 = (dwell_i == '0) ? '0 : dwell_i - DWELL_BITWIDTH'(1);
  assign slot_nxt = act_q + SLOT_BITS'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cr_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (start_i) begin
          state_d = ST_LOAD;
          cr_d    = slot_q[0];
          act_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        en_d    = 1'b1;
      end
      ST_RUN: begin
        if (sample_strb_i) begin
          // >= keeps the counter bounded if dwell_i is lowered mid-step.
          if (cnt_q >= dwell_m1) begin
            cnt_d = '0;
            en_d  = 1'b0;
            if (act_q != last_slot_i) begin
              state_d = ST_LOAD;
              cr_d    = slot_q[slot_nxt];
              act_d   = slot_nxt;
            end else if (loop_i) begin
              state_d = ST_LOAD;
              cr_d    = slot_q[0];
              act_d   = '0;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DWELL_BITWIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // Abort overrides every other transition; bus and slot index hold.
    if (stop_i) begin
      state_d = ST_IDLE;
      cr_d    = cr_q;
      act_d   = act_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_fg_profile_sequencer.sv
// Self-checking bench for fg_profile_sequencer: table rows of stimulus/expected outputs
// go through a scoreboard queue and are compared one cycle later.
module tb_fg_profile_sequencer;

  localparam logic [63:0] S0  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] S1  = 64'h8877_6655_4433_2211;
  localparam logic [63:0] S2  = 64'hF0E1_D2C3_B4A5_9687;
  localparam logic [63:0] S2M = 64'hF0E1_D2C3_B4A5_965A;

  logic        clk, rstn;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_slot;
  logic [2:0]  wr_byte;
  logic [7:0]  wr_data;
  logic        start, stop, loop_en, strb;
  logic [1:0]  last_slot;
  logic [15:0] dwell;
  logic [63:0] cr_bus;
  logic        fg_en, busy, done;
  logic [1:0]  act_slot;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        start, stop, strb;
    logic [63:0] cr;
    logic        en;
    logic [1:0]  slot;
    logic        busy, done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  fg_profile_sequencer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_slot_i    (wr_slot),
    .wr_byte_i    (wr_byte),
    .wr_data_i    (wr_data),
    .start_i      (start),
    .stop_i       (stop),
    .loop_i       (loop_en),
    .last_slot_i  (last_slot),
    .dwell_i      (dwell),
    .sample_strb_i(strb),
    .CR_bus_o     (cr_bus),
    .fg_enable_o  (fg_en),
    .active_slot_o(act_slot),
    .busy_o       (busy),
    .done_strb_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic sb, input logic [63:0] cr,
                              input logic en, input logic [1:0] sl, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.stop = sp; v.strb = sb; v.cr = cr;
    v.en = en; v.slot = sl; v.busy = bz; v.done = dn;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    start = v.start;
    stop  = v.stop;
    strb  = v.strb;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".cr"},   cr_bus,          e.cr);
    check({tag, ".en"},   64'(fg_en),      64'(e.en));
    check({tag, ".slot"}, 64'(act_slot),   64'(e.slot));
    check({tag, ".busy"}, 64'(busy),       64'(e.busy));
    check({tag, ".done"}, 64'(done),       64'(e.done));
  endtask

  task automatic wr_word(input logic [1:0] slot, input logic [63:0] word);
    for (int b = 0; b < 8; b++) begin
      wr_valid = 1'b1;
      wr_slot  = slot;
      wr_byte  = 3'(b);
      wr_data  = word[8*b +: 8];
      #1;
      check($sformatf("wr_ready_idle_s%0d_b%0d", slot, b), 64'(wr_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_byte = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; strb = 1'b0; last_slot = '0; dwell = '0;

    vecs.push_back(mk(1, 0, 0, S0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, S0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, S0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, S0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, S0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, S1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, S1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, S1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, S1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, S1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, S1, 0, 1, 0, 0));

    #12;
    check("rst.cr",    cr_bus,         64'd0);
    check("rst.en",    64'(fg_en),     64'd0);
    check("rst.slot",  64'(act_slot),  64'd0);
    check("rst.busy",  64'(busy),      64'd0);
    check("rst.done",  64'(done),      64'd0);
    check("rst.ready", 64'(wr_ready),  64'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Slot 1 gets 0x11..0x88 byte by byte
    wr_word(2'd0, S0);
    for (int b = 0; b < 8; b++) begin
      wr_valid = 1'b1; wr_slot = 2'd1; wr_byte = 3'(b); wr_data = 8'((b + 1) * 8'h11);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wr_word(2'd2, S2);

    // Two-step sequence, dwell 3, strobe during LOAD ignored
    last_slot = 2'd1; dwell = 16'd3; loop_en = 1'b0;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("seqA[%0d]", i));

    // Looping with dwell 0: one strobe per step, slots 0,1,2,0,1
    last_slot = 2'd2; dwell = 16'd0; loop_en = 1'b1;
    apply(mk(1, 0, 0, S0, 0, 0, 1, 0), "loop.start");
    apply(mk(0, 0, 0, S0, 1, 0, 1, 0), "loop.run0");
    for (int k = 1; k < 5; k++) begin
      logic [63:0] c;
      c = (k % 3 == 0) ? S0 : (k % 3 == 1) ? S1 : S2;
      apply(mk(0, 0, 1, c, 0, 2'(k % 3), 1, 0), $sformatf("loop.load%0d", k));
      apply(mk(0, 0, 0, c, 1, 2'(k % 3), 1, 0), $sformatf("loop.run%0d", k));
    end
    apply(mk(0, 1, 0, S1, 0, 1, 0, 0), "loop.stop");
    loop_en = 1'b0;

    // Active profile is write-protected; other slots accept writes
    last_slot = 2'd2; dwell = 16'd2;
    apply(mk(1, 0, 0, S0, 0, 0, 1, 0), "wp.start");
    apply(mk(0, 0, 0, S0, 1, 0, 1, 0), "wp.run0");
    apply(mk(0, 0, 1, S0, 1, 0, 1, 0), "wp.cnt0");
    apply(mk(0, 0, 1, S1, 0, 1, 1, 0), "wp.load1");
    apply(mk(0, 0, 0, S1, 1, 1, 1, 0), "wp.run1");
    wr_valid = 1'b1; wr_slot = 2'd1; wr_byte = 3'd0; wr_data = 8'hEE;
    #1;
    check("wp.ready_s1_a", 64'(wr_ready), 64'd0);
    apply(mk(0, 0, 1, S1, 1, 1, 1, 0), "wp.cnt1");
    check("wp.ready_s1_b", 64'(wr_ready), 64'd0);
    wr_slot = 2'd2; wr_data = 8'h5A;
    #1;
    check("wp.ready_s2", 64'(wr_ready), 64'd1);
    apply(mk(0, 0, 0, S1, 1, 1, 1, 0), "wp.wr2");
    wr_slot = 2'd1; wr_data = 8'hEE;
    #1;
    check("wp.ready_s1_c", 64'(wr_ready), 64'd0);
    wr_valid = 1'b0;
    apply(mk(0, 0, 1, S2M, 0, 2, 1, 0), "wp.load2");
    wr_valid = 1'b1;
    #1;
    check("wp.ready_s1_after", 64'(wr_ready), 64'd1);
    wr_valid = 1'b0;
    apply(mk(0, 0, 0, S2M, 1, 2, 1, 0), "wp.run2");
    apply(mk(0, 0, 1, S2M, 1, 2, 1, 0), "wp.cnt2");
    apply(mk(0, 0, 1, S2M, 0, 2, 1, 1), "wp.done");
    apply(mk(0, 0, 0, S2M, 0, 2, 0, 0), "wp.idle");

    // Stop beats start and a simultaneous final strobe
    last_slot = 2'd0; dwell = 16'd1;
    apply(mk(1, 1, 0, S2M, 0, 2, 0, 0), "stop.idle");
    apply(mk(1, 0, 0, S0, 0, 0, 1, 0), "stop.start");
    apply(mk(0, 0, 0, S0, 1, 0, 1, 0), "stop.run");
    apply(mk(1, 1, 1, S0, 0, 0, 0, 0), "stop.final");
    apply(mk(0, 0, 0, S0, 0, 0, 0, 0), "stop.after");

    // start held through DONE restarts the sequence
    apply(mk(1, 0, 0, S0, 0, 0, 1, 0), "rs.load");
    apply(mk(1, 0, 0, S0, 1, 0, 1, 0), "rs.run");
    apply(mk(1, 0, 1, S0, 0, 0, 1, 1), "rs.done");
    apply(mk(1, 0, 0, S0, 0, 0, 0, 0), "rs.idle");
    apply(mk(1, 0, 0, S0, 0, 0, 1, 0), "rs.reload");
    apply(mk(0, 0, 0, S0, 1, 0, 1, 0), "rs.run2");

    // Asynchronous reset in the middle of RUN
    #2;
    rstn = 1'b0;
    #1;
    check("arst.en",   64'(fg_en),    64'd0);
    check("arst.cr",   cr_bus,        64'd0);
    check("arst.busy", 64'(busy),     64'd0);
    check("arst.slot", 64'(act_slot), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 0, 0, 64'd0, 0, 0, 1, 0), "arst.slots_cleared");
    apply(mk(0, 1, 0, 64'd0, 0, 0, 0, 0), "arst.stop");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
